// File: rtl/idecode_stage.sv
// Instruction-decode stage: decodes 16-bit instruction words, buffers them
// in a 2-entry skid buffer (main + skid) and presents registered decoded
// fields downstream over a valid/ready handshake. Supports a synchronous
// flush and counts completed output handshakes.

// Pure field extraction and sign extension for one instruction word.
module idecode_decoder #(
    parameter int DATA_W = 16
) (
    input  logic [15:0]       ir,
    output logic [2:0]        opcode,
    output logic [1:0]        alu_op,
    output logic [1:0]        shift_op,
    output logic [2:0]        rn,
    output logic [2:0]        rd,
    output logic [2:0]        rm,
    output logic [2:0]        cond,
    output logic [DATA_W-1:0] sximm5,
    output logic [DATA_W-1:0] sximm8
);
    assign opcode   = ir[15:13];
    assign alu_op   = ir[12:11];
    assign rn       = ir[10:8];
    assign rd       = ir[7:5];
    assign shift_op = ir[4:3];
    assign rm       = ir[2:0];
    // Only branch-class words (opcode 001) carry a condition; other opcodes,
    // including unused ones, report cond 0.
    assign cond     = (ir[15:13] == 3'b001) ? ir[10:8] : 3'b000;
    assign sximm5   = {{(DATA_W-5){ir[4]}}, ir[4:0]};
    assign sximm8   = {{(DATA_W-8){ir[7]}}, ir[7:0]};
endmodule

module idecode_stage #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_ir,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_opcode,
    output logic [1:0]        out_alu_op,
    output logic [1:0]        out_shift_op,
    output logic [2:0]        out_rn,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rm,
    output logic [2:0]        out_cond,
    output logic [DATA_W-1:0] out_sximm5,
    output logic [DATA_W-1:0] out_sximm8,
    output logic [PC_W-1:0]   out_pc,
    output logic [CNT_W-1:0]  decode_count
);

    // Occupancy of the main/skid pair.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    typedef struct packed {
        logic [2:0]        opcode;
        logic [1:0]        alu_op;
        logic [1:0]        shift_op;
        logic [2:0]        rn;
        logic [2:0]        rd;
        logic [2:0]        rm;
        logic [2:0]        cond;
        logic [DATA_W-1:0] sximm5;
        logic [DATA_W-1:0] sximm8;
        logic [PC_W-1:0]   pc;
    } dec_t;

    logic [1:0]        state, state_d;
    dec_t              dec_in, main_q, skid_q;
    logic              accept, consume;
    logic              ld_main_in, ld_main_skid, ld_skid;
    logic [CNT_W-1:0]  cnt_q;

    logic [2:0]        d_opcode, d_rn, d_rd, d_rm, d_cond;
    logic [1:0]        d_alu_op, d_shift_op;
    logic [DATA_W-1:0] d_sximm5, d_sximm8;

    idecode_decoder #(.DATA_W(DATA_W)) u_dec (
        .ir       (in_ir),
        .opcode   (d_opcode),
        .alu_op   (d_alu_op),
        .shift_op (d_shift_op),
        .rn       (d_rn),
        .rd       (d_rd),
        .rm       (d_rm),
        .cond     (d_cond),
        .sximm5   (d_sximm5),
        .sximm8   (d_sximm8)
    );

    assign dec_in = '{opcode: d_opcode, alu_op: d_alu_op, shift_op: d_shift_op,
                      rn: d_rn, rd: d_rd, rm: d_rm, cond: d_cond,
                      sximm5: d_sximm5, sximm8: d_sximm8, pc: in_pc};

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    // Next occupancy and which register loads; flush overrides everything.
    always_comb begin
        state_d      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_d    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_d = TWO;
                        ld_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_d      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Occupancy state and handshake counter; a consume during flush is void.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            cnt_q <= '0;
        end else begin
            state <= state_d;
            if (consume && !flush)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Decoded-field registers: main feeds the outputs, skid holds the overflow word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_in)
                main_q <= dec_in;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= dec_in;
        end
    end

    assign out_opcode   = main_q.opcode;
    assign out_alu_op   = main_q.alu_op;
    assign out_shift_op = main_q.shift_op;
    assign out_rn       = main_q.rn;
    assign out_rd       = main_q.rd;
    assign out_rm       = main_q.rm;
    assign out_cond     = main_q.cond;
    assign out_sximm5   = main_q.sximm5;
    assign out_sximm8   = main_q.sximm8;
    assign out_pc       = main_q.pc;
    assign decode_count = cnt_q;

endmodule

// File: tb/tb_idecode_stage.sv
// Bench for idecode_stage: two instances share stimulus (DATA_W=16/CNT_W=16
// and DATA_W=32/CNT_W=4). Expected words come from a hand-filled vector
// table, are queued on accept and compared on each output handshake.
module tb_idecode_stage;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  alu;
        logic [1:0]  shift;
        logic [2:0]  rn;
        logic [2:0]  rd;
        logic [2:0]  rm;
        logic [2:0]  cond;
        logic [15:0] sx5;
        logic [15:0] sx8;
        logic [31:0] sx5w;
        logic [31:0] sx8w;
        logic [7:0]  pc;
    } exp_t;

    typedef struct packed {
        logic [15:0] ir;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [15:0] in_ir;
    logic [7:0]  in_pc;

    logic        in_ready, out_valid, in_ready_w, out_valid_w;
    logic [2:0]  o_opcode, o_rn, o_rd, o_rm, o_cond;
    logic [1:0]  o_alu, o_shift;
    logic [15:0] o_sx5, o_sx8, o_cnt;
    logic [7:0]  o_pc;
    logic [2:0]  w_opcode, w_rn, w_rd, w_rm, w_cond;
    logic [1:0]  w_alu, w_shift;
    logic [31:0] w_sx5, w_sx8;
    logic [7:0]  w_pc;
    logic [3:0]  w_cnt;

    vec_t        vec[7];
    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          cur_idx = 0;
    logic [15:0] cnt_exp = '0;
    logic [15:0] cnt_save;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    idecode_stage #(.DATA_W(16), .PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(o_opcode), .out_alu_op(o_alu), .out_shift_op(o_shift),
        .out_rn(o_rn), .out_rd(o_rd), .out_rm(o_rm), .out_cond(o_cond),
        .out_sximm5(o_sx5), .out_sximm8(o_sx8), .out_pc(o_pc),
        .decode_count(o_cnt)
    );

    idecode_stage #(.DATA_W(32), .PC_W(8), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_ir(in_ir), .in_pc(in_pc),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_opcode(w_opcode), .out_alu_op(w_alu), .out_shift_op(w_shift),
        .out_rn(w_rn), .out_rd(w_rd), .out_rm(w_rm), .out_cond(w_cond),
        .out_sximm5(w_sx5), .out_sximm8(w_sx8), .out_pc(w_pc),
        .decode_count(w_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] ir, input logic [2:0] opc, input logic [1:0] alu,
                                input logic [1:0] sh, input logic [2:0] rn, input logic [2:0] rd,
                                input logic [2:0] rm, input logic [2:0] cond, input logic [15:0] sx5,
                                input logic [15:0] sx8, input logic [31:0] sx5w, input logic [31:0] sx8w,
                                input logic [7:0] pc);
        vec_t v;
        v.ir = ir;
        v.e  = '{opcode: opc, alu: alu, shift: sh, rn: rn, rd: rd, rm: rm, cond: cond,
                 sx5: sx5, sx8: sx8, sx5w: sx5w, sx8w: sx8w, pc: pc};
        return v;
    endfunction

    // Scoreboard: compare on consume, enqueue on accept, drop everything on flush/reset.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("fields", {o_opcode, o_alu, o_shift, o_rn, o_rd, o_rm, o_cond, o_sx5, o_sx8, o_pc},
                        {e.opcode, e.alu, e.shift, e.rn, e.rd, e.rm, e.cond, e.sx5, e.sx8, e.pc});
                    chk("fields_w32", {out_valid_w, w_opcode, w_alu, w_shift, w_rn, w_rd, w_rm, w_cond, w_sx5, w_sx8, w_pc},
                        {1'b1, e.opcode, e.alu, e.shift, e.rn, e.rd, e.rm, e.cond, e.sx5w, e.sx8w, e.pc});
                end
                cnt_exp = cnt_exp + 16'd1;
            end
            if (in_valid && in_ready)
                q.push_back(vec[cur_idx].e);
        end
    end

    // Present one word and hold it until the stage takes it.
    task automatic send(input int idx);
        int n;
        n = 0;
        cur_idx  = idx;
        in_valid = 1'b1;
        in_ir    = vec[idx].ir;
        in_pc    = vec[idx].e.pc;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", {q.size() == 0, out_valid}, {1'b1, 1'b0});
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ir = '0; in_pc = '0;
        vec[0] = mk(16'h259F, 3'd1, 2'd0, 2'd3, 3'd5, 3'd4, 3'd7, 3'd5, 16'hFFFF, 16'hFF9F, 32'hFFFFFFFF, 32'hFFFFFF9F, 8'h10);
        vec[1] = mk(16'hD00F, 3'd6, 2'd2, 2'd1, 3'd0, 3'd0, 3'd7, 3'd0, 16'h000F, 16'h000F, 32'h0000000F, 32'h0000000F, 8'h11);
        vec[2] = mk(16'h0000, 3'd0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 32'h00000000, 32'h00000000, 8'h12);
        vec[3] = mk(16'hFFFF, 3'd7, 2'd3, 2'd3, 3'd7, 3'd7, 3'd7, 3'd0, 16'hFFFF, 16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hA3);
        vec[4] = mk(16'h3A50, 3'd1, 2'd3, 2'd2, 3'd2, 3'd2, 3'd0, 3'd2, 16'hFFF0, 16'h0050, 32'hFFFFFFF0, 32'h00000050, 8'h5C);
        vec[5] = mk(16'h8770, 3'd4, 2'd0, 2'd2, 3'd7, 3'd3, 3'd0, 3'd0, 16'hFFF0, 16'h0070, 32'hFFFFFFF0, 32'h00000070, 8'hFE);
        vec[6] = mk(16'h2B8C, 3'd1, 2'd1, 2'd1, 3'd3, 3'd4, 3'd4, 3'd3, 16'h000C, 16'hFF8C, 32'h0000000C, 32'hFFFFFF8C, 8'h01);

        // Reset state
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_count", o_cnt, 16'd0);
        chk("rst_fields", {o_opcode, o_cond, o_sx5, o_sx8, o_pc}, '0);
        chk("rst_count_w", w_cnt, 4'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: every vector streamed back to back with downstream always ready
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(i);
        drain();
        chk("count_table", o_cnt, 16'd7);

        // Backpressure: A,B fill the buffer, C is held, then all drain in order
        out_ready = 1'b0;
        send(0);
        send(1);
        cur_idx = 2; in_valid = 1'b1; in_ir = vec[2].ir; in_pc = vec[2].e.pc;
        @(negedge clk);
        chk("full_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("full_hold", {in_ready, out_valid, o_opcode, o_pc}, {1'b0, 1'b1, 3'd1, 8'h10});
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(2);
        drain();
        chk("count_bp", o_cnt, 16'd10);

        // Flush while full with a word offered and a consume in the same cycle
        out_ready = 1'b0;
        send(3);
        send(4);
        cnt_save = o_cnt;
        cur_idx = 5; in_valid = 1'b1; in_ir = vec[5].ir; in_pc = vec[5].e.pc;
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("flush_state", {out_valid, in_ready}, {1'b0, 1'b1});
        chk("flush_count", o_cnt, cnt_save);
        @(posedge clk); #1;

        // Random valid/ready pattern through the scoreboard
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            send(i % 7);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
            end
        end
        rand_rdy = 1'b0;
        drain();
        chk("count_rand", o_cnt, cnt_exp);

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(6);
        send(0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_state", {out_valid, in_ready, out_valid_w}, {1'b0, 1'b1, 1'b0});
        chk("midrst_count", {o_cnt, w_cnt}, {16'd0, 4'd0});
        q.delete();
        cnt_exp = '0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 17 back-to-back handshakes: the 4-bit counter wraps once
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(i % 7);
        drain();
        chk("wrap_count16", o_cnt, 16'd17);
        chk("wrap_count4", w_cnt, 4'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
